// File: rtl/jk_seq_if.sv
// Host-side bundle for jk_excitation_seq: sequence-memory writes, run control,
// and the JK bank state and excitation vectors coming back.
interface jk_seq_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 3
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    len;
    logic             loop_en;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic [AW-1:0]    step_idx;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_data, len, loop_en, start, stop,
        input  q, j_out, k_out, step_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, loop_en, start, stop,
        output q, j_out, k_out, step_idx, busy, done
    );
endinterface

// File: rtl/jk_excitation_seq.sv
// Steps a bank of JK flops through a stored list of target words, deriving the
// J/K excitation for each step from the JK excitation table.
module jk_excitation_seq #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DC_VAL = 0
) (
    input  logic     clk,
    input  logic     rstn,
    jk_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [WIDTH-1:0] DC_VEC = (DC_VAL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    state_e           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] q_q, j_q, k_q;
    logic [AW-1:0]    ptr_q, len_q, idx_q;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] j_d, k_d, q_d;

    // Excitation: a flop at 0 only needs J, a flop at 1 only needs K; the
    // other input is a don't-care and takes DC_VAL.
    assign target = mem_q[ptr_q];
    assign j_d    = (~q_q & target) | ( q_q & DC_VEC);
    assign k_d    = ( q_q & ~target) | (~q_q & DC_VEC);
    assign q_d    = (j_d & ~q_q) | (~k_d & q_q);

    // NOTE: the sequence memory has no reset; it holds host data across
    // resets and stays a plain RAM array rather than a bank of reset flops.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (state_q == S_IDLE)) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        state_q <= S_RUN;
                        len_q   <= bus.len;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        q_q   <= q_d;
                        j_q   <= j_d;
                        k_q   <= k_d;
                        idx_q <= ptr_q;
                        if (ptr_q != len_q) begin
                            ptr_q <= ptr_q + 1'b1;
                        end else if (bus.loop_en) begin
                            ptr_q <= '0;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q        = q_q;
    assign bus.j_out    = j_q;
    assign bus.k_out    = k_q;
    assign bus.step_idx = idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
